debounce_multi: RTL and testbench

//  N-channel parametrised button conditioner, successor to the single-channel debouncer.
//  Per channel: 2-flop synchroniser, consecutive-sample debounce filter, and a stable level output.

---
 rtl/debounce_multi.sv | 131 +++++++++++++
 tb/tb_debounce_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: per channel a 2-flop synchroniser, consecutive-sample
// debounce filter, registered press/release pulses and a one-shot long-press pulse.
module debounce_multi #(
  parameter int   N_CH        = 4,
  parameter int   DB_CYCLES   = 1048575,
  parameter int   LONG_CYCLES = 50000000,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  // Parking value after the long pulse; distinct from HOLD_LAST so the pulse cannot repeat.
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
  localparam logic              ACTIVE    = ~IDLE_LEVEL;

  typedef enum logic {
    HOLD_IDLE,
    HOLD_ARMED
  } hold_state_e;

  logic [N_CH-1:0]   sync1_q, sync2_q;
  logic [N_CH-1:0]   level_q, level_d;
  logic [N_CH-1:0]   press_q, press_d;
  logic [N_CH-1:0]   release_q, release_d;
  logic [N_CH-1:0]   long_q, long_d;
  logic [DB_W-1:0]   db_cnt_q   [N_CH];
  logic [DB_W-1:0]   db_cnt_d   [N_CH];
  logic [HOLD_W-1:0] hold_cnt_q [N_CH];
  logic [HOLD_W-1:0] hold_cnt_d [N_CH];
  hold_state_e       hold_state_q [N_CH];
  hold_state_e       hold_state_d [N_CH];

  // NOTE: combinational logic uses blocking '=' and assigns every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      db_cnt_d[i]     = db_cnt_q[i];
      hold_cnt_d[i]   = hold_cnt_q[i];
      hold_state_d[i] = hold_state_q[i];

      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
          if (sync2_q[i] == ACTIVE) press_d[i]   = 1'b1;
          else                      release_d[i] = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end

      case (hold_state_q[i])
        HOLD_IDLE: begin
          if (press_d[i]) begin
            hold_state_d[i] = HOLD_ARMED;
            hold_cnt_d[i]   = '0;
          end
        end
        HOLD_ARMED: begin
          // A release on the same edge as the terminal count wins: no long pulse.
          if (release_d[i]) begin
            hold_state_d[i] = HOLD_IDLE;
            hold_cnt_d[i]   = '0;
          end else if (hold_cnt_q[i] == HOLD_LAST) begin
            long_d[i]     = 1'b1;
            hold_cnt_d[i] = HOLD_SAT;
          end else if (hold_cnt_q[i] != HOLD_SAT) begin
            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
          end
        end
        default: begin
          hold_state_d[i] = HOLD_IDLE;
          hold_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<='; the per-channel counter arrays are
  // plain registers (not RAM) and are all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= {N_CH{IDLE_LEVEL}};
      sync2_q   <= {N_CH{IDLE_LEVEL}};
      level_q   <= {N_CH{IDLE_LEVEL}};
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_q[i]     <= '0;
        hold_cnt_q[i]   <= '0;
        hold_state_q[i] <= HOLD_IDLE;
      end
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_q[i]     <= db_cnt_d[i];
        hold_cnt_q[i]   <= hold_cnt_d[i];
        hold_state_q[i] <= hold_state_d[i];
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (2 channels, DB_CYCLES=4, LONG_CYCLES=10, active-low pins).
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_in;
  logic [1:0] btn_level, press_pulse, release_pulse, long_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         at;
    logic [1:0] p, r, l, lvl;
  } ev_t;
  ev_t sb[$];

  debounce_multi #(
    .N_CH(2), .DB_CYCLES(4), .LONG_CYCLES(10), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event at posedge count 'at' (drive happens at a negedge, first sampling edge is cyc+1).
  task automatic expect_ev(int at, logic [1:0] p, logic [1:0] r, logic [1:0] l, logic [1:0] lvl);
    ev_t e;
    e.at = at; e.p = p; e.r = r; e.l = l; e.lvl = lvl;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(string name, logic [1:0] lvl);
    check({name, "_level"}, 32'(btn_level), 32'(lvl));
    check({name, "_pulses"}, 32'({press_pulse, release_pulse, long_pulse}), 32'(0));
  endtask

  // Monitor: every cycle with any pulse high must match the next scoreboard entry.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (|{press_pulse, release_pulse, long_pulse}) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got p=%b r=%b l=%b want none (cycle %0d)",
                   press_pulse, release_pulse, long_pulse, cyc);
        end else begin
          e = sb.pop_front();
          check("ev_cycle",   32'(cyc),           32'(e.at));
          check("ev_press",   32'(press_pulse),   32'(e.p));
          check("ev_release", 32'(release_pulse), 32'(e.r));
          check("ev_long",    32'(long_pulse),    32'(e.l));
          check("ev_level",   32'(btn_level),     32'(e.lvl));
        end
      end
    end
  end

  initial begin
    int c;
    logic bounce [9];
    bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // 1: reset with pins idle
    rst_n  = 1'b0;
    btn_in = 2'b11;
    step(3);
    check_quiet("reset", 2'b11);
    rst_n = 1'b1;
    step(10);
    check_quiet("post_reset", 2'b11);

    // 2: clean press on ch0, released before the long-press count completes
    c = cyc;
    btn_in = 2'b10;
    expect_ev(c + 6, 2'b01, 2'b00, 2'b00, 2'b10);
    step(8);
    c = cyc;
    btn_in = 2'b11;
    expect_ev(c + 6, 2'b00, 2'b01, 2'b00, 2'b11);
    step(20);
    check_quiet("after_short_press", 2'b11);

    // 3: bounce shorter than 4 samples is discarded, then a held press is accepted
    foreach (bounce[k]) begin
      btn_in = {1'b1, bounce[k]};
      step(1);
    end
    step(8);
    check_quiet("bounce", 2'b11);
    c = cyc;
    btn_in = 2'b10;
    expect_ev(c + 6,  2'b01, 2'b00, 2'b00, 2'b10);
    expect_ev(c + 16, 2'b00, 2'b00, 2'b01, 2'b10);
    step(20);
    c = cyc;
    btn_in = 2'b11;
    expect_ev(c + 6, 2'b00, 2'b01, 2'b00, 2'b11);
    step(12);

    // 4: long press on ch1, held well past the long pulse (fires once only)
    c = cyc;
    btn_in = 2'b01;
    expect_ev(c + 6,  2'b10, 2'b00, 2'b00, 2'b01);
    expect_ev(c + 16, 2'b00, 2'b00, 2'b10, 2'b01);
    step(25);
    c = cyc;
    btn_in = 2'b11;
    expect_ev(c + 6, 2'b00, 2'b10, 2'b00, 2'b11);
    step(12);

    // 5: both channels pressed and released on the same edge
    c = cyc;
    btn_in = 2'b00;
    expect_ev(c + 6,  2'b11, 2'b00, 2'b00, 2'b00);
    expect_ev(c + 16, 2'b00, 2'b00, 2'b11, 2'b00);
    step(20);
    c = cyc;
    btn_in = 2'b11;
    expect_ev(c + 6, 2'b00, 2'b11, 2'b00, 2'b11);
    step(12);

    // 6: reset while ch0 is held, at hold_cnt = 5; pin stays low through reset
    c = cyc;
    btn_in = 2'b10;
    expect_ev(c + 6, 2'b01, 2'b00, 2'b00, 2'b10);
    step(11);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset_now", 2'b11);
    step(3);
    check_quiet("mid_reset", 2'b11);
    c = cyc;
    rst_n = 1'b1;
    expect_ev(c + 6,  2'b01, 2'b00, 2'b00, 2'b10);
    expect_ev(c + 16, 2'b00, 2'b00, 2'b01, 2'b10);
    step(20);
    c = cyc;
    btn_in = 2'b11;
    expect_ev(c + 6, 2'b00, 2'b01, 2'b00, 2'b11);

    // Drain the scoreboard within a bounded number of cycles.
    for (int n = 0; n < 50 && sb.size() != 0; n++) step(1);
    step(5);
    while (sb.size() != 0) begin
      ev_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got none want p=%b r=%b l=%b at cycle %0d",
               e.p, e.r, e.l, e.at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
